// File: rtl/mac_job_sequencer_pkg.sv
// Shared types and default widths for the MAC job sequencer.
// Holds the FSM state encoding and the counter-width helper.
package mac_job_sequencer_pkg;

  localparam int IBR_DEF = 8;
  localparam int OBR_DEF = 32;
  localparam int KS_DEF  = 9;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    OUT
  } mac_seq_state_e;

  // Counter must hold 0..KERNEL_SIZE.
  function automatic int cnt_w(input int ks);
    return (ks < 1) ? 1 : $clog2(ks + 1);
  endfunction

endpackage

// File: rtl/mac_job_sequencer.sv
// Runs one dot-product job per output pixel on an external MAC.
// Ports: upstream pair stream (valid/ready), MAC operand/result side, downstream result (valid/ready), sticky len_err_o.
module mac_job_sequencer
  import mac_job_sequencer_pkg::*;
#(
  parameter int INPUT_BIT_RESOLUTION  = IBR_DEF,
  parameter int OUTPUT_BIT_RESOLUTION = OBR_DEF,
  parameter int KERNEL_SIZE           = KS_DEF
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             pair_valid_i,
  output logic                             pair_ready_o,
  input  logic [INPUT_BIT_RESOLUTION-1:0]  pair_data_i,
  input  logic [INPUT_BIT_RESOLUTION-1:0]  pair_weight_i,
  input  logic [OUTPUT_BIT_RESOLUTION-1:0] pair_bias_i,
  input  logic                             pair_last_i,
  output logic                             clr_mac_o,
  output logic                             input_and_kernel_valid_o,
  output logic [INPUT_BIT_RESOLUTION-1:0]  input_data_o,
  output logic [INPUT_BIT_RESOLUTION-1:0]  kernel_weight_o,
  output logic [OUTPUT_BIT_RESOLUTION-1:0] kernel_bias_o,
  input  logic                             mac_valid_i,
  input  logic [OUTPUT_BIT_RESOLUTION-1:0] mac_data_i,
  output logic                             mac_ready_o,
  output logic                             result_valid_o,
  output logic [OUTPUT_BIT_RESOLUTION-1:0] result_data_o,
  input  logic                             result_ready_i,
  output logic                             len_err_o
);

  localparam int IBR = INPUT_BIT_RESOLUTION;
  localparam int OBR = OUTPUT_BIT_RESOLUTION;
  localparam int CW  = cnt_w(KERNEL_SIZE);

  localparam logic [CW-1:0] LAST_CNT =
    CW'(KERNEL_SIZE - 1);

  mac_seq_state_e state_q;
  mac_seq_state_e state_d;

  logic [CW-1:0] cnt_q;

  logic accept;
  logic is_final;
  logic final_acc;
  logic mac_hs;
  logic res_hs;

  logic           ikv_q;
  logic [IBR-1:0] data_q;
  logic [IBR-1:0] weight_q;
  logic [OBR-1:0] bias_q;
  logic [OBR-1:0] res_q;
  logic           err_q;

  // Handshake terms
  assign accept    = pair_valid_i & pair_ready_o;
  assign is_final  = (cnt_q == LAST_CNT);
  assign final_acc = accept & is_final;
  assign mac_hs    = mac_valid_i & mac_ready_o;
  assign res_hs    = result_valid_o & result_ready_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pair_valid_i) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = STREAM;
      end
      STREAM: begin
        if (final_acc) state_d = DRAIN;
      end
      DRAIN: begin
        if (mac_hs) state_d = OUT;
      end
      OUT: begin
        if (res_hs) begin
          state_d = pair_valid_i ? CLEAR : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control outputs decode straight from the
  // state flop, so they are glitch-free and
  // come out of reset with clr_mac_o high.
  always_comb begin
    pair_ready_o   = 1'b0;
    clr_mac_o      = 1'b0;
    mac_ready_o    = 1'b0;
    result_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr_mac_o = 1'b1;
      end
      CLEAR: begin
        clr_mac_o = 1'b1;
      end
      STREAM: begin
        pair_ready_o = 1'b1;
      end
      DRAIN: begin
        mac_ready_o = 1'b1;
      end
      OUT: begin
        result_valid_o = 1'b1;
        clr_mac_o      = 1'b1;
      end
      default: begin
        clr_mac_o = 1'b1;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      ikv_q    <= 1'b0;
      data_q   <= '0;
      weight_q <= '0;
      bias_q   <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      // Operand valid follows accepts one cycle
      // later; a cycle without a pair is a bubble.
      ikv_q <= accept;

      if (state_q == CLEAR) begin
        cnt_q <= '0;
      end

      if (accept) begin
        data_q   <= pair_data_i;
        weight_q <= pair_weight_i;
        if (cnt_q == '0) begin
          bias_q <= pair_bias_i;
        end
        cnt_q <= is_final ? '0 : cnt_q + 1'b1;
        // Count decides the job end; a disagreeing
        // last flag only raises the sticky error.
        if (is_final != pair_last_i) begin
          err_q <= 1'b1;
        end
      end

      if (mac_hs) begin
        res_q <= mac_data_i;
      end
    end
  end

  assign input_and_kernel_valid_o = ikv_q;
  assign input_data_o             = data_q;
  assign kernel_weight_o          = weight_q;
  assign kernel_bias_o            = bias_q;
  assign result_data_o            = res_q;
  assign len_err_o                = err_q;

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Bench for mac_job_sequencer with a behavioural MAC peer.
// Table of jobs with golden sums plus stall, back-to-back and reset sequences.
module tb_mac_job_sequencer;

  localparam int IBR = 8;
  localparam int OBR = 32;
  localparam int K   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           pair_valid = 1'b0;
  logic           pair_ready;
  logic [IBR-1:0] pair_data = '0;
  logic [IBR-1:0] pair_weight = '0;
  logic [OBR-1:0] pair_bias = '0;
  logic           pair_last = 1'b0;
  logic           clr_mac;
  logic           ikv;
  logic [IBR-1:0] in_d;
  logic [IBR-1:0] k_w;
  logic [OBR-1:0] k_b;
  logic           mac_valid;
  logic [OBR-1:0] mac_data;
  logic           mac_ready;
  logic           result_valid;
  logic [OBR-1:0] result_data;
  logic           result_ready = 1'b1;
  logic           len_err;

  mac_job_sequencer #(
    .INPUT_BIT_RESOLUTION (IBR),
    .OUTPUT_BIT_RESOLUTION(OBR),
    .KERNEL_SIZE          (K)
  ) dut (
    .clk_i                   (clk),
    .rst_ni                  (rst_n),
    .pair_valid_i            (pair_valid),
    .pair_ready_o            (pair_ready),
    .pair_data_i             (pair_data),
    .pair_weight_i           (pair_weight),
    .pair_bias_i             (pair_bias),
    .pair_last_i             (pair_last),
    .clr_mac_o               (clr_mac),
    .input_and_kernel_valid_o(ikv),
    .input_data_o            (in_d),
    .kernel_weight_o         (k_w),
    .kernel_bias_o           (k_b),
    .mac_valid_i             (mac_valid),
    .mac_data_i              (mac_data),
    .mac_ready_o             (mac_ready),
    .result_valid_o          (result_valid),
    .result_data_o           (result_data),
    .result_ready_i          (result_ready),
    .len_err_o               (len_err)
  );

  // Behavioural MAC: accumulates on every valid
  // cycle, offers acc+bias two cycles after K pairs.
  logic [OBR-1:0] acc = '0;
  int             mcnt = 0;
  int             mwait = 0;
  logic           mdone = 1'b0;

  always @(posedge clk) begin
    if (clr_mac) begin
      acc   <= '0;
      mcnt  <= 0;
      mwait <= 0;
      mdone <= 1'b0;
    end else begin
      if (ikv) begin
        acc  <= acc + {24'b0, in_d} * {24'b0, k_w};
        mcnt <= mcnt + 1;
      end
      if (mcnt >= K) mwait <= mwait + 1;
      if (mac_valid && mac_ready) mdone <= 1'b1;
    end
  end

  assign mac_valid = (mcnt >= K) && (mwait >= 2) && !mdone;
  assign mac_data  = acc + k_b;

  int errors = 0;
  int checks = 0;

  logic [OBR-1:0] rq[$];
  int             pq[$];

  always @(negedge clk) begin
    if (rst_n && result_valid && result_ready) begin
      rq.push_back(result_data);
      pq.push_back(mcnt);
    end
  end

  // Counts clr_mac cycles between a result
  // handshake and the next pair_ready.
  bit arm = 1'b0;
  int clr_run = 0;
  int clr_gap = -1;

  always @(negedge clk) begin
    if (rst_n && result_valid && result_ready) begin
      arm     = 1'b1;
      clr_run = 0;
    end else if (arm) begin
      if (pair_ready) begin
        arm     = 1'b0;
        clr_gap = clr_run;
      end else if (clr_mac) begin
        clr_run++;
      end
    end
  end

  task automatic chk(input string name,
                     input logic [OBR-1:0] act,
                     input logic [OBR-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout, got none expected event",
             name);
  endtask

  typedef struct {
    logic [K-1:0][IBR-1:0] d;
    logic [K-1:0][IBR-1:0] w;
    logic [OBR-1:0]        bias;
    int                    last_idx;
    int                    max_gap;
    logic [OBR-1:0]        exp_res;
    logic                  exp_err;
  } job_t;

  job_t jobs[6];

  // Called at #1 after a rising edge; returns there.
  task automatic send_job(input job_t j, input int n);
    bit hs;
    int cyc;
    int gap;
    for (int i = 0; i < n; i++) begin
      gap = (j.max_gap > 0) ?
        int'($urandom_range(0, j.max_gap)) : 0;
      pair_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      pair_valid  = 1'b1;
      pair_data   = j.d[i];
      pair_weight = j.w[i];
      pair_bias   = j.bias;
      pair_last   = (i == j.last_idx);
      hs  = 1'b0;
      cyc = 0;
      while (!hs && cyc < 300) begin
        @(negedge clk);
        hs = pair_ready;
        @(posedge clk);
        #1;
        cyc++;
      end
      if (!hs) timeout($sformatf("pair%0d accept", i));
      pair_valid = 1'b0;
      pair_last  = 1'b0;
    end
  endtask

  task automatic wait_result(output logic [OBR-1:0] r,
                             output int p,
                             output bit ok);
    int cyc = 0;
    while (rq.size() == 0 && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    ok = (rq.size() != 0);
    r  = '0;
    p  = 0;
    if (ok) begin
      r = rq.pop_front();
      p = pq.pop_front();
    end else begin
      timeout("result");
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " clr_mac"},      OBR'(clr_mac), 1);
    chk({tag, " pair_ready"},   OBR'(pair_ready), 0);
    chk({tag, " ikv"},          OBR'(ikv), 0);
    chk({tag, " input_data"},   OBR'(in_d), 0);
    chk({tag, " kernel_w"},     OBR'(k_w), 0);
    chk({tag, " kernel_b"},     k_b, 0);
    chk({tag, " mac_ready"},    OBR'(mac_ready), 0);
    chk({tag, " result_valid"}, OBR'(result_valid), 0);
    chk({tag, " result_data"},  result_data, 0);
    chk({tag, " len_err"},      OBR'(len_err), 0);
  endtask

  initial begin
    logic [OBR-1:0] r;
    int             p;
    bit             ok;
    int             cyc;

    // d, w (index 0 first), bias, last_idx, max_gap, result, err
    jobs[0] = '{'{8'd7, 8'd6, 8'd5, 8'd4, 8'd3},
                '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3},
                32'd10, 4, 0, 32'd145, 1'b0};
    jobs[1] = '{'{8'd7, 8'd6, 8'd5, 8'd4, 8'd3},
                '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3},
                32'd10, 4, 5, 32'd145, 1'b0};
    jobs[2] = '{'{8'd1, 8'd1, 8'd1, 8'd1, 8'd1},
                '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1},
                32'd0, 4, 0, 32'd5, 1'b0};
    jobs[3] = '{'{8'd255, 8'd255, 8'd255, 8'd255, 8'd255},
                '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255},
                32'd1000, 4, 2, 32'd326125, 1'b0};
    jobs[4] = '{'{8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5},
                32'd7, 4, 1, 32'd42, 1'b0};
    jobs[5] = '{'{8'd7, 8'd6, 8'd5, 8'd4, 8'd3},
                '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3},
                32'd10, 2, 0, 32'd145, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle clr_mac", OBR'(clr_mac), 1);

    for (int t = 0; t < 6; t++) begin
      send_job(jobs[t], K);
      wait_result(r, p, ok);
      if (ok) begin
        chk($sformatf("job%0d result", t), r,
            jobs[t].exp_res);
        chk($sformatf("job%0d mac pairs", t),
            OBR'(p), K);
      end
      chk($sformatf("job%0d len_err", t),
          OBR'(len_err), OBR'(jobs[t].exp_err));
    end

    // Back-to-back: second job queued during DRAIN/OUT.
    clr_gap = -1;
    send_job(jobs[0], K);
    send_job(jobs[2], K);
    wait_result(r, p, ok);
    if (ok) chk("b2b first result", r, 145);
    wait_result(r, p, ok);
    if (ok) chk("b2b second result", r, 5);
    chk("b2b clear pulse", OBR'(clr_gap), 1);
    chk("len_err sticky", OBR'(len_err), 1);

    // Downstream stall in OUT with upstream waiting.
    result_ready = 1'b0;
    send_job(jobs[0], K);
    cyc = 0;
    while (!result_valid && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!result_valid) timeout("stall result_valid");
    pair_valid  = 1'b1;
    pair_data   = 8'd1;
    pair_weight = 8'd1;
    pair_bias   = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d valid", i),
          OBR'(result_valid), 1);
      chk($sformatf("stall%0d data", i),
          result_data, 145);
      chk($sformatf("stall%0d pair_ready", i),
          OBR'(pair_ready), 0);
      chk($sformatf("stall%0d ikv", i),
          OBR'(ikv), 0);
    end
    @(posedge clk);
    #1;
    result_ready = 1'b1;
    send_job(jobs[2], K);
    wait_result(r, p, ok);
    if (ok) chk("stall held result", r, 145);
    wait_result(r, p, ok);
    if (ok) chk("after stall result", r, 5);

    // Reset in STREAM after two pairs.
    send_job(jobs[0], 2);
    @(posedge clk);
    #1;
    chk("pre-reset pair_ready", OBR'(pair_ready), 1);
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_job(jobs[0], K);
    wait_result(r, p, ok);
    if (ok) begin
      chk("post-reset result", r, 145);
      chk("post-reset mac pairs", OBR'(p), K);
    end
    chk("post-reset len_err", OBR'(len_err), 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
